ball_pocket_tracker: RTL and testbench
======================================

BALL_POCKET_TRACKER -- requirements
Module: ball_pocket_tracker

Interface
REQ-001 SHALL have parameter NUM_BALLS, default 6, meaning object balls; ball 0 is the white ball, so vectors are NUM_BALLS+1 bits.
REQ-002 SHALL have parameter NUM_HOLES, default 6, meaning pockets; hole index h reports as id h+1.
REQ-003 SHALL have parameter POCKET_PIXELS, default 8, meaning the per-frame overlap pixel count that declares a ball pocketed.
REQ-004 SHALL have parameter REPORT_GAP, default 4, meaning idle cycles between consecutive reports.
REQ-005 clk  in  1  system clock; all logic on its rising edge.
REQ-006 resetN  in  1  one clock; reset is synchronous and active-high (asserted = 1, sampled on clk).
REQ-007 startOfFrame  in  1  one-cycle frame-boundary pulse.
REQ-008 ball_dr  in  NUM_BALLS+1  per-ball pixel drawing request.
REQ-009 hole_dr  in  NUM_HOLES  per-hole pixel drawing request.
REQ-010 rerack  in  1  one-cycle pulse that restores all balls for a new stage.
REQ-011 ballhole_collide  out  NUM_BALLS+1  one-hot, one-cycle pocket report.
REQ-012 curr_Hole_id  out  3  hole id of the latest report, held until the next report; 0 = none.
REQ-013 balls_in_game  out  NUM_BALLS+1  registered mask of balls on the table.

Function
REQ-014 Each pixel cycle, for ball b, SHALL increment cnt[b] when ball_dr[b], any hole_dr bit and balls_in_game[b] are all 1.
- cnt[b] is 8 bits and saturates at 255.
REQ-015 On the first overlapping pixel of a frame, SHALL latch first_hole[b] as the lowest set hole_dr index; later overlaps in the same frame SHALL NOT change it.
REQ-016 On startOfFrame, SHALL OR (cnt[b] >= POCKET_PIXELS) into pending[b], copy first_hole[b] to rep_hole[b] for newly set bits, and clear all cnt and first-hole latches.
- The startOfFrame pixel itself SHALL count toward the new frame.
- The startOfFrame snapshot SHALL be taken in every FSM state.
REQ-017 FSM states and transitions:
- S_COLLECT -> S_REPORT when pending != 0.
- S_REPORT: for one cycle, pulse ballhole_collide[b] for the lowest set pending bit b; in the same cycle set curr_Hole_id = rep_hole[b]+1; on the following edge clear pending[b] and balls_in_game[b]; go to S_GAP.
- S_GAP: count REPORT_GAP cycles, then go to S_REPORT if pending != 0, else S_COLLECT.
REQ-018 Report latency SHALL be 2 cycles, from the startOfFrame cycle to the ballhole_collide pulse, when in S_COLLECT.
REQ-019 ballhole_collide SHALL never have more than one bit set; pulses SHALL be separated by at least REPORT_GAP+1 cycles.
REQ-020 White ball (b=0) SHALL be reported and removed exactly like object balls.
- It has priority as the lowest index.
REQ-021 A ball with balls_in_game[b]=0 SHALL never count, become pending, or be reported.
REQ-022 rerack SHALL, on the next edge:
- set balls_in_game to all ones;
- clear pending, cnt and latches;
- force S_COLLECT;
- leave curr_Hole_id unchanged.
REQ-023 rerack coinciding with S_REPORT SHALL win: no pulse is issued that cycle.
REQ-024 rerack coinciding with startOfFrame SHALL discard that snapshot.
REQ-025 Overlap count exactly POCKET_PIXELS-1 SHALL NOT pocket; exactly POCKET_PIXELS SHALL pocket.

Reset
REQ-026 While resetN=1, on each edge SHALL set:
- FSM to S_COLLECT;
- ballhole_collide=0, curr_Hole_id=0, balls_in_game=all ones;
- pending, cnt, latches and gap counter to 0.
REQ-027 Reset mid-report SHALL abort the report with no pulse; pending balls are lost.

Structure
REQ-028 SHALL place NUM_BALLS, NUM_HOLES, the state enum {S_COLLECT, S_REPORT, S_GAP} and the 3-bit hole-id type in shared package pocket_pkg.
- The game controller imports the same package.
REQ-029 SHALL use one sub-module, ball_overlap_counter: saturating counter plus first-hole latch for one ball, instantiated NUM_BALLS+1 times via generate.

Verification
REQ-030 Ball 3 overlaps hole index 1 for 8 pixels in one frame -> at startOfFrame+2, ballhole_collide=7'b0001000, curr_Hole_id=2, balls_in_game=7'b1110111.
REQ-031 Ball 3 overlaps for 7 pixels -> no pulse; balls_in_game stays 7'b1111111.
REQ-032 Balls 0 and 5 both pocketed in one frame (holes 4 and 0) -> ball 0 pulses with id 5; ball 5 pulses with id 1 exactly REPORT_GAP+1 cycles later.
REQ-033 Ball 2 already removed, ball_dr[2] overlaps 50 pixels -> no pulse.
REQ-034 rerack asserted in the S_REPORT cycle -> no pulse; balls_in_game=7'b1111111; pending=0.
REQ-035 Ball 4 overlaps hole 2 then hole 0 in the same frame -> curr_Hole_id=3; counter saturation checked with 300 overlap pixels -> single pulse.

Source files
------------

// File: rtl/pocket_pkg.sv
// Shared definitions for the pocket tracker and the game controller.
//   NUM_BALLS / NUM_HOLES : default table population (object balls, pockets)
//   state_e               : report FSM states
//   hole_id_t             : 3-bit hole index / reported hole id
//   lowest_hole()         : index of the lowest set bit of a hole vector
package pocket_pkg;

  localparam int NUM_BALLS = 6;
  localparam int NUM_HOLES = 6;
  localparam int CNT_W     = 8;

  typedef logic [2:0] hole_id_t;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_REPORT  = 2'd1,
    S_GAP     = 2'd2
  } state_e;

  // Lowest set index wins when a pixel touches several pockets at once.
  function automatic hole_id_t lowest_hole(input logic [7:0] v);
    hole_id_t r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/ball_overlap_counter.sv
// Per-ball overlap bookkeeping for one frame.
//   clk, resetN     : clock, synchronous active-high reset
//   clear           : rerack, wipes the frame state
//   sof             : frame boundary; restarts the count with this pixel
//   ovl_en          : ball pixel is drawn and the ball is still on the table
//   hole_dr         : per-hole drawing requests
//   cnt             : saturating overlap pixel count for the current frame
//   first_hole      : hole index of the first overlapping pixel this frame
module ball_overlap_counter #(
  parameter int NUM_HOLES = pocket_pkg::NUM_HOLES
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 clear,
  input  logic                 sof,
  input  logic                 ovl_en,
  input  logic [NUM_HOLES-1:0] hole_dr,
  output logic [7:0]           cnt,
  output pocket_pkg::hole_id_t first_hole
);
  import pocket_pkg::*;

  logic [7:0] cnt_q, cnt_d;
  logic       vld_q, vld_d;
  hole_id_t   fh_q, fh_d;
  logic [7:0] hv;
  logic       hit;

  always_comb begin
    hv = '0;
    hv[NUM_HOLES-1:0] = hole_dr;
    hit   = ovl_en & (|hole_dr);
    cnt_d = cnt_q;
    vld_d = vld_q;
    fh_d  = fh_q;
    if (sof) begin
      // The boundary pixel already belongs to the new frame.
      cnt_d = hit ? 8'd1 : 8'd0;
      vld_d = hit;
      fh_d  = hit ? lowest_hole(hv) : '0;
    end else if (hit) begin
      if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      if (!vld_q) begin
        vld_d = 1'b1;
        fh_d  = lowest_hole(hv);
      end
    end
    if (clear) begin
      cnt_d = '0;
      vld_d = 1'b0;
      fh_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      cnt_q <= '0;
      vld_q <= 1'b0;
      fh_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      fh_q  <= fh_d;
    end
  end

  assign cnt        = cnt_q;
  assign first_hole = fh_q;

endmodule

// File: rtl/ball_pocket_tracker.sv
// Detects balls dropping into pockets from per-pixel drawing requests and
// reports them one at a time.
//   clk, resetN      : clock, synchronous active-high reset
//   startOfFrame     : one-cycle frame boundary pulse
//   ball_dr          : per-ball drawing request, bit 0 = white ball
//   hole_dr          : per-hole drawing request
//   rerack           : restore all balls for a new stage
//   ballhole_collide : one-hot, one-cycle pocket report
//   curr_Hole_id     : id (index+1) of the latest reported pocket, 0 = none
//   balls_in_game    : balls still on the table
module ball_pocket_tracker #(
  parameter int NUM_BALLS     = pocket_pkg::NUM_BALLS,
  parameter int NUM_HOLES     = pocket_pkg::NUM_HOLES,
  parameter int POCKET_PIXELS = 8,
  parameter int REPORT_GAP    = 4
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic [NUM_BALLS:0]   ball_dr,
  input  logic [NUM_HOLES-1:0] hole_dr,
  input  logic                 rerack,
  output logic [NUM_BALLS:0]   ballhole_collide,
  output pocket_pkg::hole_id_t curr_Hole_id,
  output logic [NUM_BALLS:0]   balls_in_game
);
  import pocket_pkg::*;

  localparam int         NB1        = NUM_BALLS + 1;
  localparam logic [7:0] POCKET_THR = 8'(POCKET_PIXELS);
  localparam logic [7:0] GAP_LAST   = 8'((REPORT_GAP > 0) ? REPORT_GAP - 1 : 0);

  state_e                  state_q, state_d;
  logic [7:0]              gap_q, gap_d;
  logic [NUM_BALLS:0]      pending_q, pending_d;
  logic [NUM_BALLS:0]      big_q, big_d;
  hole_id_t [NUM_BALLS:0]  rep_hole_q, rep_hole_d;
  hole_id_t                curr_q, curr_d;

  logic [NUM_BALLS:0][7:0] cnt;
  hole_id_t [NUM_BALLS:0]  first_hole;
  logic [NUM_BALLS:0]      hit, new_hit, sel_oh;
  hole_id_t                sel_hole, report_id;

  for (genvar b = 0; b < NB1; b++) begin : g_ball
    ball_overlap_counter #(.NUM_HOLES(NUM_HOLES)) u_cnt (
      .clk        (clk),
      .resetN     (resetN),
      .clear      (rerack),
      .sof        (startOfFrame),
      .ovl_en     (ball_dr[b] & big_q[b]),
      .hole_dr    (hole_dr),
      .cnt        (cnt[b]),
      .first_hole (first_hole[b])
    );
  end

  always_comb begin
    state_d          = state_q;
    gap_d            = gap_q;
    pending_d        = pending_q;
    big_d            = big_q;
    rep_hole_d       = rep_hole_q;
    curr_d           = curr_q;
    ballhole_collide = '0;
    curr_Hole_id     = curr_q;

    // Lowest pending ball goes first, so the white ball has priority.
    sel_oh   = pending_q & (~pending_q + {{NUM_BALLS{1'b0}}, 1'b1});
    sel_hole = '0;
    for (int b = 0; b < NB1; b++) begin
      if (sel_oh[b]) sel_hole = rep_hole_q[b];
    end
    report_id = sel_hole + 3'd1;

    // Frame snapshot, taken regardless of FSM state.
    hit = '0;
    for (int b = 0; b < NB1; b++) begin
      if (startOfFrame && big_q[b] && (cnt[b] >= POCKET_THR)) hit[b] = 1'b1;
    end
    new_hit   = hit & ~pending_q;
    pending_d = pending_q | new_hit;
    for (int b = 0; b < NB1; b++) begin
      if (new_hit[b]) rep_hole_d[b] = first_hole[b];
    end

    unique case (state_q)
      S_COLLECT: begin
        if (pending_q != '0) state_d = S_REPORT;
      end
      S_REPORT: begin
        ballhole_collide = sel_oh;
        curr_Hole_id     = report_id;
        curr_d           = report_id;
        // Clearing after the snapshot OR keeps a ball that is still
        // overlapping at a coinciding frame edge from being re-queued.
        pending_d        = pending_d & ~sel_oh;
        big_d            = big_q & ~sel_oh;
        gap_d            = '0;
        state_d          = S_GAP;
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = (pending_q != '0) ? S_REPORT : S_COLLECT;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = S_COLLECT;
    endcase

    if (rerack) begin
      state_d          = S_COLLECT;
      gap_d            = '0;
      pending_d        = '0;
      big_d            = '1;
      rep_hole_d       = '0;
      curr_d           = curr_q;
      ballhole_collide = '0;
      curr_Hole_id     = curr_q;
    end

    if (resetN) begin
      ballhole_collide = '0;
      curr_Hole_id     = curr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q    <= S_COLLECT;
      gap_q      <= '0;
      pending_q  <= '0;
      big_q      <= '1;
      rep_hole_q <= '0;
      curr_q     <= '0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      pending_q  <= pending_d;
      big_q      <= big_d;
      rep_hole_q <= rep_hole_d;
      curr_q     <= curr_d;
    end
  end

  assign balls_in_game = big_q;

endmodule

// File: tb/tb_ball_pocket_tracker.sv
module tb_ball_pocket_tracker;
  import pocket_pkg::*;

  localparam int NB = 6;
  localparam int NH = 6;
  localparam int RG = 4;

  logic          clk = 1'b0;
  logic          resetN, startOfFrame, rerack;
  logic [NB:0]   ball_dr;
  logic [NH-1:0] hole_dr;
  logic [NB:0]   ballhole_collide, balls_in_game;
  hole_id_t      curr_Hole_id;

  ball_pocket_tracker #(
    .NUM_BALLS(NB), .NUM_HOLES(NH), .POCKET_PIXELS(8), .REPORT_GAP(RG)
  ) dut (
    .clk              (clk),
    .resetN           (resetN),
    .startOfFrame     (startOfFrame),
    .ball_dr          (ball_dr),
    .hole_dr          (hole_dr),
    .rerack           (rerack),
    .ballhole_collide (ballhole_collide),
    .curr_Hole_id     (curr_Hole_id),
    .balls_in_game    (balls_in_game)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [NB:0] mask;
    logic [2:0]  id;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0, n_bad = 0, n_pulse = 0;

  // Scoreboard monitor: every pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (ballhole_collide !== '0) begin
      n_pulse++;
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_pulse cyc=%0d got=%b required=none", cyc, ballhole_collide);
      end else begin
        mon_e = exp_q.pop_front();
        n_cmp++;
        if (ballhole_collide !== mon_e.mask) begin
          n_bad++;
          $display("FAIL pulse_mask cyc=%0d got=%b required=%b", cyc, ballhole_collide, mon_e.mask);
        end
        n_cmp++;
        if (curr_Hole_id !== mon_e.id) begin
          n_bad++;
          $display("FAIL pulse_hole_id cyc=%0d got=%0d required=%0d", cyc, curr_Hole_id, mon_e.id);
        end
        n_cmp++;
        if (cyc !== mon_e.cyc) begin
          n_bad++;
          $display("FAIL pulse_cycle got=%0d required=%0d", cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic drive(input logic [NB:0] bd, input logic [NH-1:0] hd,
                       input logic s, input logic rr, input logic rst);
    @(posedge clk); #1;
    ball_dr = bd; hole_dr = hd; startOfFrame = s; rerack = rr; resetN = rst;
  endtask

  task automatic idle(input int n);
    repeat (n) drive('0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic overlap(input int ball, input int hole, input int n);
    logic [NB:0]   bd;
    logic [NH-1:0] hd;
    bd = '0; bd[ball] = 1'b1;
    hd = '0; hd[hole] = 1'b1;
    repeat (n) drive(bd, hd, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sof_pulse(output int c);
    drive('0, '0, 1'b1, 1'b0, 1'b0);
    c = cyc;
  endtask

  task automatic do_rerack();
    drive('0, '0, 1'b0, 1'b1, 1'b0);
    idle(2);
  endtask

  task automatic expect_pulse(input int c, input logic [NB:0] m, input logic [2:0] id);
    exp_t e;
    e.cyc = c; e.mask = m; e.id = id;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_timeout pending_expectations=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
    idle(2);
  endtask

  task automatic test_reset();
    drive('0, '0, 1'b0, 1'b0, 1'b1);
    drive('0, '0, 1'b0, 1'b0, 1'b1);
    drive('0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (ballhole_collide !== '0) begin n_bad++; $display("FAIL reset_collide got=%b required=0", ballhole_collide); end
    n_cmp++;
    if (curr_Hole_id !== 3'd0) begin n_bad++; $display("FAIL reset_hole_id got=%0d required=0", curr_Hole_id); end
    n_cmp++;
    if (balls_in_game !== 7'b1111111) begin n_bad++; $display("FAIL reset_big got=%b required=1111111", balls_in_game); end
    idle(2);
  endtask

  task automatic test_pocket();
    int c;
    sof_pulse(c);
    overlap(3, 1, 8);
    sof_pulse(c);
    expect_pulse(c + 2, 7'b0001000, 3'd2);
    drain("pocket");
    @(negedge clk);
    n_cmp++;
    if (balls_in_game !== 7'b1110111) begin n_bad++; $display("FAIL pocket_big got=%b required=1110111", balls_in_game); end
    n_cmp++;
    if (curr_Hole_id !== 3'd2) begin n_bad++; $display("FAIL pocket_id_hold got=%0d required=2", curr_Hole_id); end
  endtask

  task automatic test_threshold();
    int c, p0;
    do_rerack();
    @(negedge clk);
    n_cmp++;
    if (balls_in_game !== 7'b1111111) begin n_bad++; $display("FAIL rerack_big got=%b required=1111111", balls_in_game); end
    n_cmp++;
    if (curr_Hole_id !== 3'd2) begin n_bad++; $display("FAIL rerack_id_kept got=%0d required=2", curr_Hole_id); end
    p0 = n_pulse;
    sof_pulse(c);
    overlap(3, 1, 7);
    sof_pulse(c);
    idle(20);
    n_cmp++;
    if (n_pulse !== p0) begin n_bad++; $display("FAIL threshold_7_pulses got=%0d required=0", n_pulse - p0); end
    n_cmp++;
    if (balls_in_game !== 7'b1111111) begin n_bad++; $display("FAIL threshold_big got=%b required=1111111", balls_in_game); end
  endtask

  task automatic test_two_balls();
    int c;
    do_rerack();
    sof_pulse(c);
    overlap(0, 4, 8);
    overlap(5, 0, 8);
    sof_pulse(c);
    expect_pulse(c + 2, 7'b0000001, 3'd5);
    expect_pulse(c + 2 + RG + 1, 7'b0100000, 3'd1);
    drain("two_balls");
    @(negedge clk);
    n_cmp++;
    if (balls_in_game !== 7'b1011110) begin n_bad++; $display("FAIL two_balls_big got=%b required=1011110", balls_in_game); end
    n_cmp++;
    if (curr_Hole_id !== 3'd1) begin n_bad++; $display("FAIL two_balls_id got=%0d required=1", curr_Hole_id); end
  endtask

  task automatic test_removed();
    int c, p0;
    do_rerack();
    sof_pulse(c);
    overlap(2, 3, 8);
    sof_pulse(c);
    expect_pulse(c + 2, 7'b0000100, 3'd4);
    drain("removed_first");
    p0 = n_pulse;
    overlap(2, 3, 50);
    sof_pulse(c);
    idle(20);
    n_cmp++;
    if (n_pulse !== p0) begin n_bad++; $display("FAIL removed_pulses got=%0d required=0", n_pulse - p0); end
    @(negedge clk);
    n_cmp++;
    if (balls_in_game !== 7'b1111011) begin n_bad++; $display("FAIL removed_big got=%b required=1111011", balls_in_game); end
  endtask

  task automatic test_rerack_report();
    int c, p0;
    do_rerack();
    p0 = n_pulse;
    sof_pulse(c);
    overlap(1, 0, 8);
    sof_pulse(c);
    idle(1);
    drive('0, '0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (ballhole_collide !== '0) begin n_bad++; $display("FAIL rerack_report_collide got=%b required=0", ballhole_collide); end
    idle(20);
    n_cmp++;
    if (n_pulse !== p0) begin n_bad++; $display("FAIL rerack_report_pulses got=%0d required=0", n_pulse - p0); end
    @(negedge clk);
    n_cmp++;
    if (balls_in_game !== 7'b1111111) begin n_bad++; $display("FAIL rerack_report_big got=%b required=1111111", balls_in_game); end
    n_cmp++;
    if (curr_Hole_id !== 3'd4) begin n_bad++; $display("FAIL rerack_report_id got=%0d required=4", curr_Hole_id); end
  endtask

  task automatic test_hole_order();
    int c, p0;
    do_rerack();
    p0 = n_pulse;
    sof_pulse(c);
    overlap(4, 2, 4);
    overlap(4, 0, 296);
    sof_pulse(c);
    expect_pulse(c + 2, 7'b0010000, 3'd3);
    drain("hole_order");
    idle(20);
    n_cmp++;
    if (n_pulse !== p0 + 1) begin n_bad++; $display("FAIL saturation_pulses got=%0d required=1", n_pulse - p0); end
    // Two pockets touched by the same pixel: lowest index (3) wins.
    sof_pulse(c);
    repeat (8) drive(7'b1000000, 6'b101000, 1'b0, 1'b0, 1'b0);
    sof_pulse(c);
    expect_pulse(c + 2, 7'b1000000, 3'd4);
    drain("multi_hole");
  endtask

  task automatic test_rerack_sof();
    int c, p0;
    do_rerack();
    p0 = n_pulse;
    sof_pulse(c);
    overlap(3, 1, 8);
    drive('0, '0, 1'b1, 1'b1, 1'b0);
    idle(20);
    n_cmp++;
    if (n_pulse !== p0) begin n_bad++; $display("FAIL rerack_sof_pulses got=%0d required=0", n_pulse - p0); end
    @(negedge clk);
    n_cmp++;
    if (balls_in_game !== 7'b1111111) begin n_bad++; $display("FAIL rerack_sof_big got=%b required=1111111", balls_in_game); end
  endtask

  task automatic test_reset_mid_report();
    int c, p0;
    p0 = n_pulse;
    sof_pulse(c);
    overlap(1, 2, 8);
    sof_pulse(c);
    idle(1);
    drive('0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (ballhole_collide !== '0) begin n_bad++; $display("FAIL reset_mid_collide got=%b required=0", ballhole_collide); end
    idle(20);
    n_cmp++;
    if (n_pulse !== p0) begin n_bad++; $display("FAIL reset_mid_pulses got=%0d required=0", n_pulse - p0); end
    @(negedge clk);
    n_cmp++;
    if (curr_Hole_id !== 3'd0) begin n_bad++; $display("FAIL reset_mid_id got=%0d required=0", curr_Hole_id); end
    n_cmp++;
    if (balls_in_game !== 7'b1111111) begin n_bad++; $display("FAIL reset_mid_big got=%b required=1111111", balls_in_game); end
  endtask

  initial begin
    resetN = 1'b1; startOfFrame = 1'b0; rerack = 1'b0;
    ball_dr = '0; hole_dr = '0;
    test_reset();
    test_pocket();
    test_threshold();
    test_two_balls();
    test_removed();
    test_rerack_report();
    test_hole_order();
    test_rerack_sof();
    test_reset_mid_report();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
